gray_updown_counter: RTL and testbench

Parametrised successor to the fixed 4-bit Gray counter. Generalises the width and adds an enable, up/down direction, a synchronous parallel load, and a selectable wrap or saturate mode. Provides registered Gray and binary outputs, a terminal-count flag and a wrap pulse. Used as a pointer or sequence generator in clock-domain-crossing FIFOs and in encoder/position logic.

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_bin2gray.sv | 15 +
 rtl/gray_updown_counter.sv | 92 +++++++++
 tb/tb_gray_updown_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray up/down counter family.
//   bin2gray  - binary to reflected-binary Gray conversion (up to 32 bits)
//   gray2bin  - inverse conversion, used when checking Gray outputs
//   UP / DN   - encodings of the up_dn direction input
//   MODE_WRAP / MODE_SAT - encodings of the WRAP parameter
package gray_pkg;

    localparam logic UP        = 1'b1;
    localparam logic DN        = 1'b0;
    localparam bit   MODE_WRAP = 1'b1;
    localparam bit   MODE_SAT  = 1'b0;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, so walk
    // down from the MSB carrying the running parity.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// gray_bin2gray: combinational N-bit binary to Gray converter.
//   bin  - binary input value
//   gray - Gray-coded equivalent of bin
module gray_bin2gray
    import gray_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = N'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: parametrised binary/Gray up/down counter with
// enable, synchronous parallel load and wrap-or-saturate end behaviour.
//   clk      - rising-edge clock
//   reset    - synchronous, active-high; loads RESET_VAL
//   en       - count enable, one step per cycle
//   up_dn    - 1 = count up, 0 = count down
//   load     - synchronous parallel load of load_val (overrides en)
//   load_val - binary value to load
//   gray     - registered Gray count, always matching bin
//   bin      - registered binary count
//   tc       - combinational terminal count for the current direction
//   wrap     - registered one-cycle pulse after a wrap-around step
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int           N         = 4,
    parameter bit           WRAP      = MODE_WRAP,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray,
    output logic [N-1:0] bin,
    output logic         tc,
    output logic         wrap
);

    localparam logic [N-1:0] MAX_VAL   = '1;
    localparam logic [N-1:0] RESET_GRY = N'(bin2gray(32'(RESET_VAL)));

    logic [N-1:0] b_q;
    logic [N-1:0] gray_q;
    logic         wrap_q;
    logic [N-1:0] b_next;
    logic [N-1:0] gray_next;
    logic         wrap_next;
    logic         at_end;

    // At the end of the range for the requested direction; also drives tc.
    assign at_end = (up_dn == UP) ? (b_q == MAX_VAL) : (b_q == '0);

    // NOTE: every variable gets its default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        b_next    = b_q;
        wrap_next = 1'b0;
        if (load) begin
            b_next = load_val;
        end else if (en) begin
            if (at_end) begin
                // Saturate mode simply keeps the default hold value.
                if (WRAP == MODE_WRAP) begin
                    b_next    = (up_dn == UP) ? '0 : MAX_VAL;
                    wrap_next = 1'b1;
                end
            end else begin
                b_next = (up_dn == UP) ? b_q + 1'b1 : b_q - 1'b1;
            end
        end
    end

    // Converting the next value (not the current one) keeps gray aligned
    // with bin without an extra register stage.
    gray_bin2gray #(.N(N)) u_bin2gray (
        .bin  (b_next),
        .gray (gray_next)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q    <= RESET_VAL;
            gray_q <= RESET_GRY;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_next;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
        end
    end

    assign bin  = b_q;
    assign gray = gray_q;
    assign wrap = wrap_q;
    assign tc   = at_end;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: directed, table-driven bench for the N=4 counter
// in wrap mode, plus hand-written saturation sequences on a WRAP=0 copy.
module tb_gray_updown_counter;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] gray_w, bin_w, gray_s, bin_s;
    logic       tc_w, wrap_w, tc_s, wrap_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.N(4), .WRAP(1'b1), .RESET_VAL(4'd0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray(gray_w), .bin(bin_w), .tc(tc_w), .wrap(wrap_w)
    );

    gray_updown_counter #(.N(4), .WRAP(1'b0), .RESET_VAL(4'd0)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .gray(gray_s), .bin(bin_s), .tc(tc_s), .wrap(wrap_s)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       ud;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_wrap;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic ld, logic [3:0] lv, logic e,
                               logic ud, logic [3:0] eb, logic [3:0] eg,
                               logic ew, logic et);
        vec_t r;
        r.rst = rst; r.ld = ld; r.lv = lv; r.en = e; r.ud = ud;
        r.exp_bin = eb; r.exp_gray = eg; r.exp_wrap = ew; r.exp_tc = et;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 ns after the edge.
    task automatic step(input logic rst, input logic ld, input logic [3:0] lv,
                        input logic e, input logic ud);
        reset = rst; load = ld; load_val = lv; en = e; up_dn = ud;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev_gray;

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = UP; load = 1'b0; load_val = '0;

        // rst ld  lv  en ud  bin   gray  wrap tc
        vecs.push_back(v(1, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0));   // reset state
        // 16 up steps through the full Gray cycle
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h1, 4'h1, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h2, 4'h3, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h3, 4'h2, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h4, 4'h6, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h5, 4'h7, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h6, 4'h5, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h7, 4'h4, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h8, 4'hC, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h9, 4'hD, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'hA, 4'hF, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'hB, 4'hE, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'hC, 4'hA, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'hD, 4'hB, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'hE, 4'h9, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'hF, 4'h8, 0, 1));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1, 0));   // wrap up
        vecs.push_back(v(0, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0));   // pulse ends
        // down-wrap from reset
        vecs.push_back(v(1, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1));   // tc at 0, down
        vecs.push_back(v(0, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 0, 4'hE, 4'h9, 0, 0));   // down step
        // load ignores en/up_dn, then an up step
        vecs.push_back(v(0, 1, 4'h5, 1, 0, 4'h5, 4'h7, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h6, 4'h5, 0, 0));
        // reset beats load and en
        vecs.push_back(v(0, 1, 4'h7, 0, 1, 4'h7, 4'h4, 0, 0));
        vecs.push_back(v(1, 1, 4'hA, 1, 1, 4'h0, 4'h0, 0, 0));
        // hold at 0011 while up_dn toggles
        vecs.push_back(v(0, 1, 4'h3, 0, 1, 4'h3, 4'h2, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 0, 0, 4'h3, 4'h2, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 0, 1, 4'h3, 4'h2, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 0, 0, 4'h3, 4'h2, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 0, 1, 4'h3, 4'h2, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 0, 0, 4'h3, 4'h2, 0, 0));
        // direction change mid-count
        vecs.push_back(v(0, 0, 4'h0, 1, 1, 4'h4, 4'h6, 0, 0));
        vecs.push_back(v(0, 0, 4'h0, 1, 0, 4'h3, 4'h2, 0, 0));

        prev_gray = 4'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud);
            check($sformatf("v%0d bin", i),  bin_w,  vecs[i].exp_bin);
            check($sformatf("v%0d gray", i), gray_w, vecs[i].exp_gray);
            check($sformatf("v%0d wrap", i), wrap_w, vecs[i].exp_wrap);
            check($sformatf("v%0d tc", i),   tc_w,   vecs[i].exp_tc);
            check($sformatf("v%0d gray2bin", i), gray2bin(32'(gray_w)),
                  32'(vecs[i].exp_bin));
            if (!vecs[i].rst && !vecs[i].ld && vecs[i].en)
                check($sformatf("v%0d gray one-bit step", i),
                      $countones(gray_w ^ prev_gray), 1);
            prev_gray = gray_w;
        end

        // Saturate mode: up end
        step(0, 1, 4'hE, 0, 1);
        check("sat load bin", bin_s, 4'hE);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'h0, 1, 1);
            check($sformatf("sat up%0d bin", i),  bin_s,  4'hF);
            check($sformatf("sat up%0d gray", i), gray_s, 4'h8);
            check($sformatf("sat up%0d wrap", i), wrap_s, 1'b0);
            check($sformatf("sat up%0d tc", i),   tc_s,   1'b1);
        end

        // Saturate mode: down end
        step(0, 1, 4'h1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'h0, 1, 0);
            check($sformatf("sat dn%0d bin", i),  bin_s,  4'h0);
            check($sformatf("sat dn%0d gray", i), gray_s, 4'h0);
            check($sformatf("sat dn%0d wrap", i), wrap_s, 1'b0);
            check($sformatf("sat dn%0d tc", i),   tc_s,   1'b1);
        end

        // tc is independent of en and follows up_dn combinationally
        up_dn = UP;
        #1;
        check("sat tc up at 0", tc_s, 1'b0);
        up_dn = DN;
        #1;
        check("sat tc dn at 0", tc_s, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
